// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency unified memory between instruction fetch (IF) and
//   the MEM-stage load/store path (LDUR, STUR, LDURB, STURB). One access is in flight at a time,
//   sequenced IDLE -> ISSUE -> WAIT -> DONE. Data normally wins contention, but after STARVE_MAX
//   consecutive data grants with a fetch pending, the fetch is served.
//
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   if_req/if_addr             fetch request (level, held until if_valid) and address
//   if_rdata/if_valid          fetched instruction and its one-cycle completion pulse
//   d_req/d_wr/d_addr/d_wdata  data request (level, held until d_valid), store flag, address, data
//   d_xfer                     4'b1000 = 8 bytes, 4'b0001 = 1 byte, anything else is illegal
//   d_rdata/d_valid/d_err      load data, completion pulse, illegal-transfer flag
//   mem_en                     one-cycle access strobe; mem_wr/addr/wdata/xfer held for the access
//   mem_rdata                  read data, valid exactly MEM_LAT cycles after mem_en
//   stall_if/stall_mem         requester waiting (combinational)

module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_valid,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_xfer,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              d_err,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_xfer,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam int unsigned CntW = $clog2(MEM_LAT + 1);
   localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

   localparam logic [3:0] XferDword = 4'b1000;
   localparam logic [3:0] XferByte  = 4'b0001;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e            state_q, state_d;
   logic              data_owner_q, data_owner_d;  // 1: data path owns the access
   logic [CntW-1:0]   count_q, count_d;
   logic [StW-1:0]    starve_q, starve_d;
   logic              if_valid_q, if_valid_d;
   logic              d_valid_q, d_valid_d;
   logic              d_err_q, d_err_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_xfer_q, mem_xfer_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic xfer_legal;
   logic starve_full;
   logic fetch_wins;

   assign xfer_legal  = (d_xfer == XferDword) || (d_xfer == XferByte);
   assign starve_full = (starve_q == StW'(STARVE_MAX));
   // Data has priority unless the fetch side has been passed over STARVE_MAX times in a row.
   assign fetch_wins  = if_req && (!d_req || starve_full);

   always_comb begin
      state_d      = state_q;
      data_owner_d = data_owner_q;
      count_d      = count_q;
      starve_d     = starve_q;
      if_valid_d   = 1'b0;
      d_valid_d    = 1'b0;
      d_err_d      = 1'b0;
      mem_en_d     = 1'b0;
      mem_wr_d     = mem_wr_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_xfer_d   = mem_xfer_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;

      unique case (state_q)
         StIdle: begin
            if (fetch_wins) begin
               data_owner_d = 1'b0;
               starve_d     = '0;
               mem_en_d     = 1'b1;
               mem_wr_d     = 1'b0;
               mem_addr_d   = if_addr;
               mem_wdata_d  = '0;
               mem_xfer_d   = XferDword;
               state_d      = StIssue;
            end else if (d_req) begin
               data_owner_d = 1'b1;
               // Only consecutive data grants over a waiting fetch count toward starvation.
               if (!if_req) begin
                  starve_d = '0;
               end else if (!starve_full) begin
                  starve_d = starve_q + StW'(1);
               end
               if (xfer_legal) begin
                  mem_en_d    = 1'b1;
                  mem_wr_d    = d_wr;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  mem_xfer_d  = d_xfer;
                  state_d     = StIssue;
               end else begin
                  // Illegal size: complete with an error without touching memory.
                  d_valid_d = 1'b1;
                  d_err_d   = 1'b1;
                  state_d   = StDone;
               end
            end
         end
         StIssue: begin
            count_d = CntW'(MEM_LAT);
            state_d = StWait;
         end
         StWait: begin
            // Last wait cycle: mem_rdata is valid now.
            if (count_q == CntW'(1)) begin
               count_d = '0;
               state_d = StDone;
               if (data_owner_q) begin
                  d_valid_d = 1'b1;
                  if (!mem_wr_q) begin
                     d_rdata_d = (mem_xfer_q == XferByte) ? DATA_W'(mem_rdata[7:0]) : mem_rdata;
                  end
               end else begin
                  if_valid_d = 1'b1;
                  if_rdata_d = mem_rdata[31:0];
               end
            end else begin
               count_d = count_q - CntW'(1);
            end
         end
         StDone: begin
            // Requests are not sampled here, so a still-held request is not re-granted.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         data_owner_q <= 1'b0;
         count_q      <= '0;
         starve_q     <= '0;
         if_valid_q   <= 1'b0;
         d_valid_q    <= 1'b0;
         d_err_q      <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_xfer_q   <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         data_owner_q <= data_owner_d;
         count_q      <= count_d;
         starve_q     <= starve_d;
         if_valid_q   <= if_valid_d;
         d_valid_q    <= d_valid_d;
         d_err_q      <= d_err_d;
         mem_en_q     <= mem_en_d;
         mem_wr_q     <= mem_wr_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_xfer_q   <= mem_xfer_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign if_valid  = if_valid_q;
   assign if_rdata  = if_rdata_q;
   assign d_valid   = d_valid_q;
   assign d_err     = d_err_q;
   assign d_rdata   = d_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_xfer  = mem_xfer_q;

   assign stall_if  = if_req & ~if_valid_q;
   assign stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Randomized bench for mem_port_arbiter. The reference model works at transaction level: when
//   the arbiter is free and a request is present it picks a winner, then schedules the absolute
//   cycles of mem_en and the completion pulse plus the values each output must show. The bench
//   also acts as the fixed-latency memory and as both requesters.

module tb_mem_port_arbiter;

   localparam int ADDR_W     = 64;
   localparam int DATA_W     = 64;
   localparam int MEM_LAT    = 2;
   localparam int STARVE_MAX = 3;
   localparam int NCYC       = 3000;
   localparam int PH_A       = 40;  // both requesters saturated, legal transfers only

   logic              clk;
   logic              reset;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_valid;
   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [3:0]        d_xfer;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;
   logic              d_err;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_xfer;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall_if;
   logic              stall_mem;

   mem_port_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MEM_LAT   (MEM_LAT),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_valid (if_valid),
      .d_req    (d_req),
      .d_wr     (d_wr),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_xfer   (d_xfer),
      .d_rdata  (d_rdata),
      .d_valid  (d_valid),
      .d_err    (d_err),
      .mem_en   (mem_en),
      .mem_wr   (mem_wr),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_xfer (mem_xfer),
      .mem_rdata(mem_rdata),
      .stall_if (stall_if),
      .stall_mem(stall_mem)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // Memory contents as a pure function of address.
   function automatic logic [63:0] mem_f(input logic [63:0] a);
      return {a[31:0] ^ 32'hDEAD_BEEF, a[63:32] ^ 32'h5A5A_C3C3};
   endfunction

   // Reference model state
   int          starve;
   int          idle_cyc;
   int          exp_en_cyc;
   int          exp_v_cyc;
   bit          exp_own_if;
   bit          exp_err;
   bit          exp_wr;
   bit          exp_d_upd;
   logic [63:0] exp_addr;
   logic [63:0] exp_wdata;
   logic [3:0]  exp_xfer;
   logic [31:0] exp_if_pend;
   logic [63:0] exp_d_pend;
   logic [31:0] persist_if;
   logic [63:0] persist_d;

   bit owners[$];
   bit pat[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   task automatic model_reset();
      starve     = 0;
      exp_en_cyc = -100;
      exp_v_cyc  = -100;
      exp_err    = 1'b0;
      exp_d_upd  = 1'b0;
      persist_if = '0;
      persist_d  = '0;
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_if_valid"}, if_valid, 0);
      chk({pfx, "_d_valid"}, d_valid, 0);
      chk({pfx, "_d_err"}, d_err, 0);
      chk({pfx, "_mem_en"}, mem_en, 0);
      chk({pfx, "_mem_wr"}, mem_wr, 0);
      chk({pfx, "_mem_addr"}, mem_addr, 0);
      chk({pfx, "_mem_wdata"}, mem_wdata, 0);
      chk({pfx, "_mem_xfer"}, mem_xfer, 0);
      chk({pfx, "_if_rdata"}, if_rdata, 0);
      chk({pfx, "_d_rdata"}, d_rdata, 0);
   endtask

   task automatic model_decide(input int c);
      logic [63:0] v;
      if (c >= idle_cyc && (if_req || d_req)) begin
         if (if_req && (!d_req || starve == STARVE_MAX)) begin
            starve      = 0;
            exp_own_if  = 1'b1;
            exp_err     = 1'b0;
            exp_wr      = 1'b0;
            exp_addr    = if_addr;
            exp_xfer    = 4'b1000;
            v           = mem_f(if_addr);
            exp_if_pend = v[31:0];
            exp_en_cyc  = c + 1;
            exp_v_cyc   = c + MEM_LAT + 2;
            idle_cyc    = c + MEM_LAT + 3;
         end else begin
            if (!if_req) starve = 0;
            else if (starve < STARVE_MAX) starve = starve + 1;
            exp_own_if = 1'b0;
            if (d_xfer == 4'b1000 || d_xfer == 4'b0001) begin
               exp_err    = 1'b0;
               exp_wr     = d_wr;
               exp_addr   = d_addr;
               exp_wdata  = d_wdata;
               exp_xfer   = d_xfer;
               exp_d_upd  = !d_wr;
               v          = mem_f(d_addr);
               exp_d_pend = (d_xfer == 4'b0001) ? {56'b0, v[7:0]} : v;
               exp_en_cyc = c + 1;
               exp_v_cyc  = c + MEM_LAT + 2;
               idle_cyc   = c + MEM_LAT + 3;
            end else begin
               exp_err    = 1'b1;
               exp_d_upd  = 1'b0;
               exp_en_cyc = -100;
               exp_v_cyc  = c + 1;
               idle_cyc   = c + 2;
            end
         end
      end
   endtask

   task automatic new_data_req(input bit allow_illegal);
      int r;
      int x;
      d_req   = 1'b1;
      d_wr    = 1'($urandom_range(0, 1));
      d_addr  = {$urandom, $urandom};
      d_wdata = {$urandom, $urandom};
      r = $urandom_range(0, 7);
      if (allow_illegal && r == 0) begin
         x = $urandom_range(0, 15);
         if (x == 1 || x == 8) x = 4;
         d_xfer = 4'(x);
      end else if (r < 4) begin
         d_xfer = 4'b0001;
      end else begin
         d_xfer = 4'b1000;
      end
   endtask

   initial begin
      bit ev;
      bit ev_if;
      bit ev_d;
      bit rst_pend;
      bit phase_a;
      int p_req;
      int p_renew;

      reset     = 1'b1;
      if_req    = 1'b0;
      if_addr   = '0;
      d_req     = 1'b0;
      d_wr      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      d_xfer    = 4'b1000;
      mem_rdata = '0;
      rst_pend  = 1'b1;
      model_reset();
      idle_cyc = 0;

      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      chk("reset_stall_if", stall_if, 0);
      chk("reset_stall_mem", stall_mem, 0);

      for (int c = 0; c < NCYC; c++) begin
         cyc = c;
         if (c != 0) begin
            @(posedge clk);
            #1;
         end
         if (rst_pend) begin
            reset    = 1'b0;
            rst_pend = 1'b0;
         end
         phase_a = (c < PH_A);

         ev    = (c == exp_v_cyc);
         ev_if = ev && exp_own_if;
         ev_d  = ev && !exp_own_if;
         if (ev_if) persist_if = exp_if_pend;
         if (ev_d && exp_d_upd) persist_d = exp_d_pend;

         chk("mem_en", mem_en, (c == exp_en_cyc));
         chk("if_valid", if_valid, ev_if);
         chk("d_valid", d_valid, ev_d);
         chk("d_err", d_err, ev_d && exp_err);
         chk("if_rdata", if_rdata, persist_if);
         chk("d_rdata", d_rdata, persist_d);
         if (exp_en_cyc >= 0 && c >= exp_en_cyc && c <= exp_v_cyc) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wr", mem_wr, exp_wr);
            chk("mem_xfer", mem_xfer, exp_xfer);
            if (exp_wr) chk("mem_wdata", mem_wdata, exp_wdata);
         end
         if (phase_a && (if_valid || d_valid)) owners.push_back(d_valid);

         // Requesters: hold until completion, then drop or immediately ask again.
         p_req   = phase_a ? 100 : ((c >= 1500) ? 80 : 30);
         p_renew = phase_a ? 100 : ((c >= 1500) ? 80 : 40);
         if (if_req && ev_if) begin
            if ($urandom_range(0, 99) < p_renew) if_addr = {$urandom, $urandom};
            else if_req = 1'b0;
         end else if (!if_req && $urandom_range(0, 99) < p_req) begin
            if_req  = 1'b1;
            if_addr = {$urandom, $urandom};
         end
         if (d_req && ev_d) begin
            if ($urandom_range(0, 99) < p_renew) new_data_req(!phase_a);
            else d_req = 1'b0;
         end else if (!d_req && $urandom_range(0, 99) < p_req) begin
            new_data_req(!phase_a);
         end

         // Memory: real data exactly MEM_LAT cycles after the strobe, junk otherwise.
         if (exp_en_cyc >= 0 && c == exp_en_cyc + MEM_LAT) mem_rdata = mem_f(exp_addr);
         else mem_rdata = {$urandom, $urandom};

         #1;
         chk("stall_if", stall_if, if_req & ~ev_if);
         chk("stall_mem", stall_mem, d_req & ~ev_d);

         if (!phase_a && $urandom_range(0, 99) == 0) begin
            #1 reset = 1'b1;
            #1 chk_all_zero("midreset");
            model_reset();
            idle_cyc = c + 1;
            rst_pend = 1'b1;
         end else begin
            model_decide(c);
         end
      end

      chk("contention_grants", (owners.size() >= 5), 1);
      for (int i = 0; i < 5; i++) begin
         if (i < owners.size()) chk($sformatf("grant_order_%0d", i), owners[i], pat[i]);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
